// File: rtl/pi_err_gen.sv
// Measurement-to-error front end for a PI loop: block-averages measurement samples,
// subtracts the average from a setpoint, then scales and saturates the result.
module pi_err_gen #(
  parameter int wmeas = 16,
  parameter int win   = 18,
  parameter int wdec  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [wmeas-1:0] meas_in,
  input  logic                    meas_strobe,
  input  logic signed [wmeas-1:0] setpoint,
  input  logic [wdec-1:0]         dec_log2,
  input  logic                    wrap,
  input  logic [2:0]              err_shift,
  input  logic                    clear,
  output logic signed [win-1:0]   err_out,
  output logic                    strobe_out,
  output logic                    sat_flag
);

  localparam int cw = (1 << wdec) - 1;
  localparam int aw = wmeas + cw;
  localparam int ww = (wmeas + 8 > win) ? wmeas + 8 : win;
  localparam logic signed [ww-1:0]  max_w = {{(ww-win+1){1'b0}}, {(win-1){1'b1}}};
  localparam logic signed [ww-1:0]  min_w = {{(ww-win+1){1'b1}}, {(win-1){1'b0}}};
  localparam logic signed [win-1:0] max_o = {1'b0, {(win-1){1'b1}}};
  localparam logic signed [win-1:0] min_o = {1'b1, {(win-1){1'b0}}};

  logic signed [aw-1:0]    acc;
  logic signed [aw-1:0]    acc_sum;
  logic [cw-1:0]           count;
  logic [cw-1:0]           last_count;
  logic [wdec-1:0]         dec_lat;
  logic [wdec-1:0]         dec_eff;
  logic                    block_done;

  logic                    s1_valid;
  logic signed [aw-1:0]    s1_sum;
  logic [wdec-1:0]         s1_dec;

  logic signed [wmeas-1:0] avg;
  logic signed [wmeas:0]   diff_raw;
  logic signed [wmeas:0]   diff;

  logic                    s2_valid;
  logic signed [wmeas:0]   s2_diff;
  logic [2:0]              s2_shift;

  logic signed [ww-1:0]    diff_w;
  logic signed [ww-1:0]    shifted;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [win-1:0]   sat_val;

  // The first sample of a block uses the live dec_log2, later ones the latched copy.
  always_comb begin
    dec_eff    = (count == '0) ? dec_log2 : dec_lat;
    last_count = (cw'(1) << dec_eff) - cw'(1);
    acc_sum    = acc + {{cw{meas_in[wmeas-1]}}, meas_in};
    block_done = meas_strobe && !clear && (count == last_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      dec_lat  <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_dec   <= '0;
    end else begin
      s1_valid <= block_done;
      if (clear) begin
        acc   <= '0;
        count <= '0;
      end else if (meas_strobe) begin
        if (count == '0)
          dec_lat <= dec_log2;
        if (block_done) begin
          acc    <= '0;
          count  <= '0;
          s1_sum <= acc_sum;
          s1_dec <= dec_eff;
        end else begin
          acc   <= acc_sum;
          count <= count + cw'(1);
        end
      end
    end
  end

  // Floor average, then a modular (phase) or full-range difference.
  always_comb begin
    avg      = wmeas'(s1_sum >>> s1_dec);
    diff_raw = {setpoint[wmeas-1], setpoint} - {avg[wmeas-1], avg};
    diff     = wrap ? {diff_raw[wmeas-1], diff_raw[wmeas-1:0]} : diff_raw;
  end

  always_comb begin
    diff_w  = {{(ww-wmeas-1){s2_diff[wmeas]}}, s2_diff};
    shifted = diff_w <<< s2_shift;
    sat_hi  = shifted > max_w;
    sat_lo  = shifted < min_w;
    sat_val = shifted[win-1:0];
    if (sat_hi)
      sat_val = max_o;
    else if (sat_lo)
      sat_val = min_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_diff    <= '0;
      s2_shift   <= '0;
      strobe_out <= 1'b0;
      err_out    <= '0;
      sat_flag   <= 1'b0;
    end else begin
      s2_valid   <= s1_valid;
      strobe_out <= s2_valid;
      if (s1_valid) begin
        s2_diff  <= diff;
        s2_shift <= err_shift;
      end
      if (s2_valid) begin
        err_out  <= sat_val;
        sat_flag <= sat_hi || sat_lo;
      end
    end
  end

endmodule

// File: doc/pi_err_gen.md
PI_ERR_GEN -- requirements
Module: pi_err_gen

Interface
REQ-001 The block SHALL have parameter wmeas, default 16, meaning measurement and setpoint width.
REQ-002 The block SHALL have parameter win, default 18, meaning error output width, constrained to win >= wmeas+1.
REQ-003 The block SHALL have parameter wdec, default 4, meaning width of dec_log2.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port meas_in, input, signed wmeas bits: measurement sample.
REQ-007 The block SHALL have port meas_strobe, input, 1 bit: meas_in valid this cycle.
REQ-008 The block SHALL have port setpoint, input, signed wmeas bits: loop target.
REQ-009 The block SHALL have port dec_log2, input, wdec bits: block length N = 2^dec_log2.
REQ-010 The block SHALL have port wrap, input, 1 bit: 1 = phase mode, difference taken modulo 2^wmeas.
REQ-011 The block SHALL have port err_shift, input, 3 bits: left shift applied to the difference.
REQ-012 The block SHALL have port clear, input, 1 bit: synchronous discard of the partial block.
REQ-013 The block SHALL have port err_out, output, signed win bits: error word feeding the PI loop errin.
REQ-014 The block SHALL have port strobe_out, output, 1 bit: one-cycle pulse, err_out valid.
REQ-015 The block SHALL have port sat_flag, output, 1 bit: last err_out was saturated.

Function
REQ-016 Stage 1 SHALL accumulate meas_in on each meas_strobe into a signed accumulator of wmeas+2^wdec-1 bits, with no overflow possible.
REQ-017 dec_log2 SHALL be latched on the first accepted sample of a block (count==0); changes mid-block SHALL take effect on the next block.
REQ-018 The sample counter SHALL count 0..N-1; on the strobe with count==N-1, the block SHALL complete, the counter SHALL return to 0, and the accumulator SHALL reload with 0 plus no carry-over.
REQ-019 With dec_log2=0, every accepted sample SHALL complete a block.
REQ-020 Stage 2, on block completion, SHALL form avg = sum >>> latched dec_log2 (arithmetic shift, floor), truncated to wmeas bits.
REQ-021 Stage 2 SHALL sample setpoint, wrap and err_shift in the same cycle and compute diff = setpoint - avg as a wmeas+1-bit signed value.
REQ-022 With wrap=1, diff SHALL be truncated to wmeas bits and sign-extended (modular wrap); with wrap=0, the full wmeas+1 bits SHALL be kept.
REQ-023 Stage 3 SHALL compute diff << err_shift, saturate it to the signed win range (max 2^(win-1)-1, min -2^(win-1)), and register the result to err_out.
REQ-024 sat_flag SHALL be registered alongside err_out and updated only when strobe_out fires.
REQ-025 Latency: a completing meas_strobe in cycle k SHALL produce strobe_out high in cycle k+3 for exactly one cycle.
REQ-026 The pipeline SHALL accept meas_strobe every cycle; back-to-back completions (dec_log2=0) SHALL yield strobe_out every cycle.
REQ-027 err_out and sat_flag SHALL hold their values between strobe_out pulses.
REQ-028 clear SHALL zero the accumulator and counter; if clear and meas_strobe coincide, the sample SHALL be discarded.
REQ-029 clear SHALL NOT cancel blocks already in stages 2-3.

Reset
REQ-030 While rst_n=0, the accumulator, counter, latched dec_log2, all pipeline registers, err_out, strobe_out and sat_flag SHALL be 0.
REQ-031 A reset asserted mid-block SHALL discard the partial block; after release, the first accepted sample SHALL start a new block.

Verification
REQ-032 dec_log2=2, setpoint=150, shift=0, samples 100,102,98,100 -> strobe_out 3 cycles after the 4th strobe, err_out=50, sat_flag=0.
REQ-033 dec_log2=0, setpoint=32767, meas=-32768: wrap=1 -> err_out=-1; wrap=0 -> err_out=65535.
REQ-034 wrap=0, shift=7, diff=65535 -> err_out=131071, sat_flag=1; setpoint=-32768, meas=32767 -> err_out=-131072.
REQ-035 dec_log2=1, setpoint=0, samples -1,-2 -> avg=-2, err_out=2 (floor rounding).
REQ-036 dec_log2=2: 2 samples, then clear (or rst_n pulse), then 4 samples of 10, setpoint=0 -> single strobe_out, err_out=-10.
REQ-037 dec_log2=0, strobe held high for 8 cycles with ramp input -> 8 consecutive strobe_out pulses, each err_out matching its sample.
